// File: rtl/odometry_integrator.sv
`timescale 1ns/1ps
// Odometry integrator: integrates global-frame VX/VY/WZ over a fixed sample
// period into pose X, Y (saturating) and THETA in degrees, wrapped to
// [-180, 180). One shared signed multiplier, sequenced by a small FSM.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for READY; latches VX/VY/WZ when it arrives
//   MX     | xs = VX * DT
//   MY     | ys = VY * DT
//   MW     | ws = WZ * DT
//   MDEG   | ts = ws * RAD2DEG (heading step, degrees)
//   ACC    | X/Y saturating accumulate, T widened accumulate
//   WRAP   | fold T by one turn per cycle until it is in [-180, 180)
//   OUT    | publish pose, pulse DONE, back to IDLE
module odometry_integrator #(
    parameter int N_WIDTH   = 32,
    parameter int Q_WIDTH   = 15,
    parameter int DT_Q      = 328,
    parameter int RAD2DEG_Q = 1877468
) (
    input  logic               ODOMETRY_INTEGRATOR_CLOCK_50,
    input  logic               ODOMETRY_INTEGRATOR_RESET_InLow,
    input  logic               ODOMETRY_INTEGRATOR_CLEAR_In,
    input  logic               ODOMETRY_INTEGRATOR_READY_In,
    input  logic [N_WIDTH-1:0] ODOMETRY_INTEGRATOR_VX_InBus,
    input  logic [N_WIDTH-1:0] ODOMETRY_INTEGRATOR_VY_InBus,
    input  logic [N_WIDTH-1:0] ODOMETRY_INTEGRATOR_WZ_InBus,
    output logic               ODOMETRY_INTEGRATOR_BUSY_Out,
    output logic               ODOMETRY_INTEGRATOR_DONE_Out,
    output logic [N_WIDTH-1:0] ODOMETRY_INTEGRATOR_X_OutBus,
    output logic [N_WIDTH-1:0] ODOMETRY_INTEGRATOR_Y_OutBus,
    output logic [N_WIDTH-1:0] ODOMETRY_INTEGRATOR_THETA_OutBus
);

    localparam logic signed [N_WIDTH-1:0] DT_C      = N_WIDTH'(DT_Q);
    localparam logic signed [N_WIDTH-1:0] R2D_C     = N_WIDTH'(RAD2DEG_Q);
    localparam logic signed [N_WIDTH:0]   T_HI      = (N_WIDTH+1)'(180 * (2 ** Q_WIDTH));
    localparam logic signed [N_WIDTH:0]   T_LO      = -T_HI;
    localparam logic signed [N_WIDTH:0]   T_SPAN    = (N_WIDTH+1)'(360 * (2 ** Q_WIDTH));
    localparam logic        [N_WIDTH-1:0] SAT_MAX   = {1'b0, {(N_WIDTH-1){1'b1}}};
    localparam logic        [N_WIDTH-1:0] SAT_MIN   = {1'b1, {(N_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MX,
        S_MY,
        S_MW,
        S_MDEG,
        S_ACC,
        S_WRAP,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [N_WIDTH-1:0] vx_q, vx_d;
    logic [N_WIDTH-1:0] vy_q, vy_d;
    logic [N_WIDTH-1:0] wz_q, wz_d;
    logic [N_WIDTH-1:0] xs_q, xs_d;
    logic [N_WIDTH-1:0] ys_q, ys_d;
    logic [N_WIDTH-1:0] ws_q, ws_d;
    logic [N_WIDTH-1:0] ts_q, ts_d;
    logic [N_WIDTH-1:0] x_q, x_d;
    logic [N_WIDTH-1:0] y_q, y_d;
    logic signed [N_WIDTH:0] t_q, t_d;
    logic [N_WIDTH-1:0] x_out_q, x_out_d;
    logic [N_WIDTH-1:0] y_out_q, y_out_d;
    logic [N_WIDTH-1:0] t_out_q, t_out_d;
    logic               done_q, done_d;

    logic signed [N_WIDTH-1:0]   mul_a;
    logic signed [N_WIDTH-1:0]   mul_b;
    logic signed [2*N_WIDTH-1:0] mul_prod;
    logic        [N_WIDTH-1:0]   mul_res;
    logic                        mul_unused;
    logic signed [N_WIDTH:0]     t_sum;

    // Two's-complement add with clamping to the N_WIDTH signed range.
    function automatic logic [N_WIDTH-1:0] sat_add(input logic [N_WIDTH-1:0] a,
                                                    input logic [N_WIDTH-1:0] b);
        logic [N_WIDTH:0] s;
        s = {a[N_WIDTH-1], a} + {b[N_WIDTH-1], b};
        if (s[N_WIDTH] != s[N_WIDTH-1]) begin
            sat_add = s[N_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[N_WIDTH-1:0];
        end
    endfunction

    // Shared multiplier operand select, driven purely by the current state.
    always_comb begin
        mul_a = vx_q;
        mul_b = DT_C;
        case (state_q)
            S_MY:    mul_a = vy_q;
            S_MW:    mul_a = wz_q;
            S_MDEG: begin
                mul_a = ws_q;
                mul_b = R2D_C;
            end
            default: ;
        endcase
    end

    // Taking bits [Q+N-1:Q] of the full product is the arithmetic shift
    // (floor) followed by truncation to N bits.
    assign mul_prod   = mul_a * mul_b;
    assign mul_res    = mul_prod[Q_WIDTH+N_WIDTH-1:Q_WIDTH];
    assign mul_unused = ^{mul_prod[2*N_WIDTH-1:Q_WIDTH+N_WIDTH], mul_prod[Q_WIDTH-1:0]};

    // Heading sum is one bit wider so a full-scale step cannot overflow.
    assign t_sum = t_q + $signed({ts_q[N_WIDTH-1], ts_q});

    // Next-state and datapath update; CLEAR overrides everything at the end.
    always_comb begin
        state_d = state_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        wz_d    = wz_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        ws_d    = ws_q;
        ts_d    = ts_q;
        x_d     = x_q;
        y_d     = y_q;
        t_d     = t_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        t_out_d = t_out_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ODOMETRY_INTEGRATOR_READY_In) begin
                    vx_d    = ODOMETRY_INTEGRATOR_VX_InBus;
                    vy_d    = ODOMETRY_INTEGRATOR_VY_InBus;
                    wz_d    = ODOMETRY_INTEGRATOR_WZ_InBus;
                    state_d = S_MX;
                end
            end
            S_MX: begin
                xs_d    = mul_res;
                state_d = S_MY;
            end
            S_MY: begin
                ys_d    = mul_res;
                state_d = S_MW;
            end
            S_MW: begin
                ws_d    = mul_res;
                state_d = S_MDEG;
            end
            S_MDEG: begin
                ts_d    = mul_res;
                state_d = S_ACC;
            end
            S_ACC: begin
                x_d     = sat_add(x_q, xs_q);
                y_d     = sat_add(y_q, ys_q);
                t_d     = t_sum;
                state_d = S_WRAP;
            end
            S_WRAP: begin
                if (t_q >= T_HI) begin
                    t_d = t_q - T_SPAN;
                end else if (t_q < T_LO) begin
                    t_d = t_q + T_SPAN;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                x_out_d = x_q;
                y_out_d = y_q;
                t_out_d = t_q[N_WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ODOMETRY_INTEGRATOR_CLEAR_In) begin
            state_d = S_IDLE;
            vx_d    = '0;
            vy_d    = '0;
            wz_d    = '0;
            xs_d    = '0;
            ys_d    = '0;
            ws_d    = '0;
            ts_d    = '0;
            x_d     = '0;
            y_d     = '0;
            t_d     = '0;
            x_out_d = '0;
            y_out_d = '0;
            t_out_d = '0;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge ODOMETRY_INTEGRATOR_CLOCK_50 or negedge ODOMETRY_INTEGRATOR_RESET_InLow) begin
        if (!ODOMETRY_INTEGRATOR_RESET_InLow) begin
            state_q <= S_IDLE;
            vx_q    <= '0;
            vy_q    <= '0;
            wz_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            ws_q    <= '0;
            ts_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            t_q     <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            t_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            wz_q    <= wz_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            ws_q    <= ws_d;
            ts_q    <= ts_d;
            x_q     <= x_d;
            y_q     <= y_d;
            t_q     <= t_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            t_out_q <= t_out_d;
            done_q  <= done_d;
        end
    end

    assign ODOMETRY_INTEGRATOR_BUSY_Out     = (state_q != S_IDLE);
    assign ODOMETRY_INTEGRATOR_DONE_Out     = done_q;
    assign ODOMETRY_INTEGRATOR_X_OutBus     = x_out_q;
    assign ODOMETRY_INTEGRATOR_Y_OutBus     = y_out_q;
    assign ODOMETRY_INTEGRATOR_THETA_OutBus = t_out_q;

endmodule

// File: tb/tb_odometry_integrator.sv
`timescale 1ns/1ps
// Bench for odometry_integrator: table of directed update runs plus a few
// hand-written sequences for clear, ignored READY and mid-update reset.
module tb_odometry_integrator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        ready;
    logic [31:0] vx, vy, wz;
    logic        busy, done;
    logic [31:0] x, y, t;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] vx;
        logic [31:0] vy;
        logic [31:0] wz;
        int          n;
        bit          clr;
        logic [31:0] ex;
        logic [31:0] ey;
        logic [31:0] et;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    odometry_integrator dut (
        .ODOMETRY_INTEGRATOR_CLOCK_50     (clk),
        .ODOMETRY_INTEGRATOR_RESET_InLow  (rst_n),
        .ODOMETRY_INTEGRATOR_CLEAR_In     (clear),
        .ODOMETRY_INTEGRATOR_READY_In     (ready),
        .ODOMETRY_INTEGRATOR_VX_InBus     (vx),
        .ODOMETRY_INTEGRATOR_VY_InBus     (vy),
        .ODOMETRY_INTEGRATOR_WZ_InBus     (wz),
        .ODOMETRY_INTEGRATOR_BUSY_Out     (busy),
        .ODOMETRY_INTEGRATOR_DONE_Out     (done),
        .ODOMETRY_INTEGRATOR_X_OutBus     (x),
        .ODOMETRY_INTEGRATOR_Y_OutBus     (y),
        .ODOMETRY_INTEGRATOR_THETA_OutBus (t)
    );

    always #10 clk = ~clk;

    // DONE pulses are counted on the rising edge; the test reads the count at falling edges.
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
    endtask

    // One READY pulse; latency counted in rising edges after the edge that samples READY.
    task automatic do_update(input int exp_lat, input string name);
        int lat;
        lat = 0;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk({name, " latency"}, lat, exp_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;

        vecs[0]  = '{32'd32768, 32'd0, 32'd0, 100, 1'b1, 32'd32800, 32'd0, 32'd0, 7};
        vecs[1]  = '{32'd0, 32'(-16384), 32'd0, 10, 1'b1, 32'd0, 32'(-1640), 32'd0, 7};
        vecs[2]  = '{32'(-1), 32'd1, 32'(-1), 3, 1'b1, 32'(-3), 32'd0, 32'(-174), 7};
        vecs[3]  = '{32'd0, 32'd0, 32'd32768, 1, 1'b1, 32'd0, 32'd0, 32'd18793, 7};
        vecs[4]  = '{32'd0, 32'd0, 32'd3276800, 3, 1'b1, 32'd0, 32'd0, 32'd5637903, 7};
        vecs[5]  = '{32'd0, 32'd0, 32'd3276800, 1, 1'b0, 32'd0, 32'd0, 32'(-4279276), 8};
        vecs[6]  = '{32'h7FFF_FFFF, 32'd0, 32'd0, 99, 1'b1, 32'd2128084893, 32'd0, 32'd0, 7};
        vecs[7]  = '{32'h7FFF_FFFF, 32'd0, 32'd0, 1, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'd0, 7};
        vecs[8]  = '{32'h7FFF_FFFF, 32'd0, 32'd0, 3, 1'b0, 32'h7FFF_FFFF, 32'd0, 32'd0, 7};
        vecs[9]  = '{32'd0, 32'd0, 32'(-3276800), 3, 1'b1, 32'd0, 32'd0, 32'(-5637906), 7};
        vecs[10] = '{32'd0, 32'd0, 32'(-3276800), 1, 1'b0, 32'd0, 32'd0, 32'd4279272, 8};
        vecs[11] = '{32'h8000_0000, 32'd0, 32'd0, 100, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 7};

        rst_n = 1'b0;
        clear = 1'b0;
        ready = 1'b0;
        vx    = 32'd0;
        vy    = 32'd0;
        wz    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset x", x, 32'd0);
        chk("reset y", y, 32'd0);
        chk("reset theta", t, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].clr) pulse_clear();
            vx = vecs[i].vx;
            vy = vecs[i].vy;
            wz = vecs[i].wz;
            d0 = done_cnt;
            for (int u = 0; u < vecs[i].n; u++) begin
                do_update(vecs[i].lat, $sformatf("vec%0d upd%0d", i, u));
            end
            @(negedge clk);
            chk($sformatf("vec%0d x", i), x, vecs[i].ex);
            chk($sformatf("vec%0d y", i), y, vecs[i].ey);
            chk($sformatf("vec%0d theta", i), t, vecs[i].et);
            chk($sformatf("vec%0d done count", i), 32'(done_cnt - d0), 32'(vecs[i].n));
        end

        // CLEAR three cycles after READY aborts the update.
        vx = 32'd32768;
        vy = 32'd0;
        wz = 32'd0;
        d0 = done_cnt;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        chk("abort busy during update", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        chk("abort busy after clear", {31'd0, busy}, 32'd0);
        chk("abort x", x, 32'd0);
        chk("abort y", y, 32'd0);
        chk("abort theta", t, 32'd0);
        repeat (10) @(negedge clk);
        chk("abort no done", 32'(done_cnt - d0), 32'd0);

        // READY while busy is dropped: one DONE, one step.
        d0 = done_cnt;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        @(negedge clk);
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy ready done count", 32'(done_cnt - d0), 32'd1);
        chk("busy ready x", x, 32'd328);

        // CLEAR together with READY in IDLE: clear wins.
        d0 = done_cnt;
        @(negedge clk); clear = 1'b1; ready = 1'b1;
        @(negedge clk); clear = 1'b0; ready = 1'b0;
        chk("clear+ready busy", {31'd0, busy}, 32'd0);
        chk("clear+ready x", x, 32'd0);
        repeat (12) @(negedge clk);
        chk("clear+ready no done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset in the middle of an update.
        do_update(7, "pre-reset");
        @(negedge clk);
        chk("pre-reset x", x, 32'd328);
        d0 = done_cnt;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset x", x, 32'd0);
        chk("async reset busy", {31'd0, busy}, 32'd0);
        chk("async reset done", {31'd0, done}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("after reset no done", 32'(done_cnt - d0), 32'd0);
        chk("after reset x", x, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
